// File: rtl/ov7670_capture.sv
// ov7670_capture
// Frame-capture stage behind the OV7670 camera interface. Bytes sampled on
// p_clock are paired into RGB555 pixels. Each pixel that survives
// power-of-two decimation is emitted with a linear frame-buffer write address.
// The block captures one frame per start, or back-to-back frames while
// continuous is set.
module ov7670_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DECIM_LOG2 = 0,
    parameter int ADDR_W     = 19
) (
    input  logic              p_clock,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        p_data,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              pix_valid,
    output logic [14:0]       pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              err_line,
    output logic              err_frame
);

    // col and row must be able to hold H_ACTIVE / V_ACTIVE themselves:
    // col saturates there, and row == V_ACTIVE marks a complete frame.
    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam int H_DEC = H_ACTIVE >> DECIM_LOG2;

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_ACTIVE);
    localparam logic [COL_W-1:0] COL_MASK = COL_W'((1 << DECIM_LOG2) - 1);
    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'((1 << DECIM_LOG2) - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        WAIT_VS_FALL,
        ACTIVE
    } state_t;

    state_t           state;
    logic             href_q;
    logic             phase;
    logic [6:0]       hi_byte;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             keep;

    // First pipeline stage: the pixel as formed on its second byte, plus its
    // coordinates. The address is computed from these one edge later.
    logic             s1_vld;
    logic [14:0]      s1_data;
    logic [COL_W-1:0] s1_col;
    logic [ROW_W-1:0] s1_row;

    // A completed pixel is kept only on the decimation grid. With
    // DECIM_LOG2 == 0 both masks are zero, so every pixel is kept.
    assign keep = ((col & COL_MASK) == '0) && ((row & ROW_MASK) == '0);

    // Previous href sample, used for falling-edge detection. Outside ACTIVE
    // it is forced low so that a stale high cannot fake a line end on entry.
    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            href_q <= 1'b0;
        end else begin
            href_q <= (state == ACTIVE) ? href : 1'b0;
        end
    end

    // Capture sequencer: arming, frame sync, byte pairing, line/frame counting.
    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
            s1_vld     <= 1'b0;
            s1_data    <= '0;
            s1_col     <= '0;
            s1_row     <= '0;
        end else begin
            frame_done <= 1'b0;
            s1_vld     <= 1'b0;
            case (state)
                IDLE: begin
                    col   <= '0;
                    row   <= '0;
                    phase <= 1'b0;
                    if (start) begin
                        state     <= WAIT_VS;
                        busy      <= 1'b1;
                        err_line  <= 1'b0;
                        err_frame <= 1'b0;
                    end
                end
                // Wait for a vsync pulse so capture never begins mid-frame.
                WAIT_VS: begin
                    col   <= '0;
                    row   <= '0;
                    phase <= 1'b0;
                    if (vsync) state <= WAIT_VS_FALL;
                end
                WAIT_VS_FALL: begin
                    col   <= '0;
                    row   <= '0;
                    phase <= 1'b0;
                    if (!vsync) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (row == ROW_MAX) begin
                        // The last line ended on the previous edge.
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        if (continuous) begin
                            state <= WAIT_VS;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (vsync) begin
                        // A short frame: resynchronise and capture the new one.
                        err_frame <= 1'b1;
                        state     <= WAIT_VS_FALL;
                    end else if (href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi_byte <= p_data[6:0];
                        end else if (col != COL_MAX) begin
                            s1_vld  <= keep;
                            s1_data <= {hi_byte, p_data};
                            s1_col  <= col;
                            s1_row  <= row;
                            col     <= col + COL_ONE;
                        end else begin
                            // Overlong line: drop the pixel, col stays at max.
                            err_line <= 1'b1;
                        end
                    end else if (href_q) begin
                        // Line end: it must hold exactly H_ACTIVE whole pixels.
                        if ((col != COL_MAX) || phase) err_line <= 1'b1;
                        row   <= row + ROW_ONE;
                        col   <= '0;
                        phase <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage: strobe for one cycle with data and the linear write address.
    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_addr  <= '0;
        end else begin
            pix_valid <= s1_vld;
            if (s1_vld) begin
                pix_data <= s1_data;
                pix_addr <= ADDR_W'(s1_row >> DECIM_LOG2) * ADDR_W'(H_DEC)
                          + ADDR_W'(s1_col >> DECIM_LOG2);
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: two instances (d=0 and d=1) share one stimulus.
// Frame-level model predicts every strobe (cycle, data, address) and every
// frame_done pulse; status outputs are compared at quiet points.
module tb_ov7670_capture;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 19;

    logic       p_clock    = 1'b0;
    logic       reset_n    = 1'b1;
    logic       vsync      = 1'b0;
    logic       href       = 1'b0;
    logic [7:0] p_data     = 8'h00;
    logic       start      = 1'b0;
    logic       continuous = 1'b0;

    logic [1:0]           busy, pv, fd, el, ef;
    logic [1:0][14:0]     pd;
    logic [1:0][AW-1:0]   pa;
    logic [1:0][7:0]      fc;

    always #5 p_clock = ~p_clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM_LOG2(g), .ADDR_W(AW)) dut (
            .p_clock(p_clock), .reset_n(reset_n), .vsync(vsync), .href(href),
            .p_data(p_data), .start(start), .continuous(continuous),
            .busy(busy[g]), .pix_valid(pv[g]), .pix_data(pd[g]), .pix_addr(pa[g]),
            .frame_done(fd[g]), .frame_cnt(fc[g]), .err_line(el[g]), .err_frame(ef[g]));
    end

    int cyc = 0;
    always @(posedge p_clock) cyc <= cyc + 1;

    typedef struct packed {
        int            t;
        logic [14:0]   data;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t eq  [2][$];
    int   fdq [2][$];

    // model: 0 idle, 1 armed (waiting for frame start), 2 capturing
    int m_st = 0, m_row = 0, m_fcnt = 0;
    bit m_el = 0, m_ef = 0;
    bit want_start = 0, busy_must = 0;

    int n_checks = 0, n_errors = 0;
    int n_str [2];
    int n_fd  [2];
    logic [14:0]   last_d [2];
    logic [AW-1:0] last_a [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            n_str[i] = 0; n_fd[i] = 0; last_d[i] = '0; last_a[i] = '0;
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_row = 0; m_fcnt = 0; m_el = 0; m_ef = 0;
        for (int i = 0; i < 2; i++) begin
            eq[i].delete();
            fdq[i].delete();
        end
    endtask

    // one camera clock of stimulus, applied away from the sampling edge
    task automatic step(input logic v, input logic h, input logic [7:0] b);
        @(negedge p_clock);
        vsync  = v;
        href   = h;
        p_data = b;
        start  = want_start;
        if (want_start && m_st == 0) begin
            m_st = 1; m_el = 0; m_ef = 0;
        end
        want_start = 0;
    endtask

    task automatic do_start();
        want_start = 1;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
    endtask

    // mode 0: fixed 7C/1F, mode 1: pixel value = full-res address with bit 7 set, else random
    task automatic send_pix(input int c, input int mode);
        logic [7:0]  hi, lo;
        logic [14:0] px;
        exp_t        e;
        px = 15'(m_row * H + c);
        case (mode)
            0:       begin hi = 8'h7C; lo = 8'h1F; end
            1:       begin hi = {1'b1, px[14:8]}; lo = px[7:0]; end
            default: begin hi = 8'($urandom); lo = 8'($urandom); end
        endcase
        step(0, 1, hi);
        step(0, 1, lo);
        if (m_st == 2 && c < H) begin
            for (int d = 0; d < 2; d++) begin
                if ((c % (1 << d)) == 0 && (m_row % (1 << d)) == 0) begin
                    e.t    = cyc + 2;
                    e.data = {hi[6:0], lo};
                    e.addr = AW'((m_row >> d) * (H >> d) + (c >> d));
                    eq[d].push_back(e);
                end
            end
        end
    endtask

    task automatic send_line(input int c0, input int np, input bit ex, input int mode);
        for (int c = c0; c < np; c++) send_pix(c, mode);
        if (ex) step(0, 1, 8'($urandom));
        step(0, 0, 8'h00);
        if (m_st == 2) begin
            if (np != H || ex) m_el = 1;
            m_row++;
            if (m_row == V) begin
                for (int d = 0; d < 2; d++) fdq[d].push_back(cyc + 2);
                m_fcnt++;
                m_st = continuous ? 1 : 0;
            end
        end
        step(0, 0, 8'h00);
    endtask

    task automatic vs_pulse();
        if (m_st == 2) m_ef = 1;
        if (m_st != 0) begin m_st = 2; m_row = 0; end
        repeat (3) step(1, 0, 8'h00);
        repeat (2) step(0, 0, 8'h00);
    endtask

    task automatic send_frame(input int mode, input int br, input int bn, input bit bx);
        vs_pulse();
        for (int r = 0; r < V; r++)
            send_line(0, (r == br) ? bn : H, (r == br) ? bx : 1'b0, mode);
    endtask

    task automatic settle_check(input string tag);
        repeat (3) step(0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_busy%0d", tag, i),      64'(busy[i]), 64'(m_st != 0));
            check($sformatf("%s_err_line%0d", tag, i),  64'(el[i]),   64'(m_el));
            check($sformatf("%s_err_frame%0d", tag, i), 64'(ef[i]),   64'(m_ef));
            check($sformatf("%s_frame_cnt%0d", tag, i), 64'(fc[i]),   64'(m_fcnt % 256));
            check($sformatf("%s_pending%0d", tag, i),   64'(eq[i].size() + fdq[i].size()), 64'(0));
        end
    endtask

    // per-cycle compare of strobes and frame_done against the model
    initial forever begin
        @(negedge p_clock);
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                while (eq[i].size() > 0 && eq[i][0].t < cyc) begin
                    n_checks++; n_errors++;
                    $display("FAIL pix%0d_missing: no strobe, expected one at cycle %0d", i, eq[i][0].t);
                    void'(eq[i].pop_front());
                end
                if (pv[i]) begin
                    n_str[i]++; last_d[i] = pd[i]; last_a[i] = pa[i];
                    if (eq[i].size() > 0 && eq[i][0].t == cyc) begin
                        check($sformatf("pix%0d_data", i), 64'(pd[i]), 64'(eq[i][0].data));
                        check($sformatf("pix%0d_addr", i), 64'(pa[i]), 64'(eq[i][0].addr));
                        void'(eq[i].pop_front());
                    end else begin
                        n_checks++; n_errors++;
                        $display("FAIL pix%0d_unexpected: strobe at cycle %0d addr %0d, expected none", i, cyc, pa[i]);
                    end
                end
                while (fdq[i].size() > 0 && fdq[i][0] < cyc) begin
                    n_checks++; n_errors++;
                    $display("FAIL frame_done%0d_missing: no pulse, expected one at cycle %0d", i, fdq[i][0]);
                    void'(fdq[i].pop_front());
                end
                begin
                    bit exp_fd;
                    exp_fd = (fdq[i].size() > 0 && fdq[i][0] == cyc);
                    if (fd[i] || exp_fd)
                        check($sformatf("frame_done%0d_at_%0d", i, cyc), 64'(fd[i]), 64'(exp_fd));
                    if (fd[i]) n_fd[i]++;
                    if (exp_fd) void'(fdq[i].pop_front());
                end
                if (busy_must) check($sformatf("busy_hold%0d", i), 64'(busy[i]), 64'(1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_counts();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge p_clock);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs%0d", i),
                  64'({busy[i], pv[i], pd[i], pa[i], fd[i], fc[i], el[i], ef[i]}), 64'(0));
        reset_n = 1'b1;
        repeat (2) step(0, 0, 8'h00);

        // full frame of 7C/1F
        clr_counts(); do_start(); send_frame(0, -1, 0, 0); settle_check("t1");
        check("t1_strobes0", 64'(n_str[0]), 64'(32));
        check("t1_data0",    64'(last_d[0]), 64'(15'h7C1F));
        check("t1_addr0",    64'(last_a[0]), 64'(31));
        check("t1_strobes1", 64'(n_str[1]), 64'(8));
        check("t1_done0",    64'(n_fd[0]), 64'(1));
        check("t1_cnt0",     64'(fc[0]), 64'(1));
        check("t1_busy0",    64'(busy[0]), 64'(0));

        // pixel = address, bit 7 of hi byte set
        clr_counts(); do_start(); send_frame(1, -1, 0, 0); settle_check("t2");
        check("t2_strobes1", 64'(n_str[1]), 64'(8));
        check("t2_data1",    64'(last_d[1]), 64'(22));
        check("t2_addr1",    64'(last_a[1]), 64'(7));
        check("t2_data0",    64'(last_d[0]), 64'(31));

        // 7-pixel line on row 2
        clr_counts(); do_start(); send_frame(2, 2, 7, 0); settle_check("t3");
        check("t3_err_line", 64'(el[0]), 64'(1));
        check("t3_done",     64'(n_fd[0]), 64'(1));

        // odd byte count on row 1
        clr_counts(); do_start(); send_frame(2, 1, 8, 1); settle_check("t4");
        check("t4_err_line", 64'(el[0]), 64'(1));

        // 9 pixels on row 3: excess dropped
        clr_counts(); do_start(); send_frame(2, 3, 9, 0); settle_check("t5");
        check("t5_strobes0", 64'(n_str[0]), 64'(32));
        check("t5_err_line", 64'(el[1]), 64'(1));

        // vsync after 3 of 4 lines, then a full frame
        clr_counts(); do_start(); vs_pulse();
        for (int r = 0; r < 3; r++) send_line(0, H, 0, 2);
        send_frame(2, -1, 0, 0); settle_check("t6");
        check("t6_err_frame", 64'(ef[0]), 64'(1));
        check("t6_done",      64'(n_fd[0]), 64'(1));
        check("t6_cnt",       64'(fc[0]), 64'(6));

        // continuous: three back-to-back frames
        continuous = 1'b1; clr_counts(); do_start(); busy_must = 1;
        repeat (3) send_frame(2, -1, 0, 0);
        settle_check("t7");
        busy_must = 0;
        check("t7_done", 64'(n_fd[0]), 64'(3));
        check("t7_cnt",  64'(fc[1]), 64'(9));
        continuous = 1'b0;
        send_frame(2, -1, 0, 0); settle_check("t7b");
        check("t7b_busy", 64'(busy[0]), 64'(0));

        // reset mid-line, then start while the camera is mid-frame
        do_start(); vs_pulse(); send_line(0, H, 0, 2);
        for (int c = 0; c < 3; c++) send_pix(c, 2);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("midline_reset%0d", i),
                  64'({busy[i], pv[i], pd[i], pa[i], fd[i], fc[i], el[i], ef[i]}), 64'(0));
        model_reset();
        step(0, 1, 8'($urandom));
        step(0, 1, 8'($urandom));
        reset_n = 1'b1;
        want_start = 1;
        send_line(3, H, 0, 2);
        send_line(0, H, 0, 2);
        send_line(0, H, 0, 2);
        clr_counts();
        send_frame(2, -1, 0, 0); settle_check("t8");
        check("t8_cnt",     64'(fc[0]), 64'(1));
        check("t8_strobes", 64'(n_str[0]), 64'(32));

        // frame counter wrap
        continuous = 1'b1; do_start();
        repeat (254) send_frame(2, -1, 0, 0);
        settle_check("t9a");
        check("t9_cnt255", 64'(fc[0]), 64'(255));
        send_frame(2, -1, 0, 0); settle_check("t9b");
        check("t9_cnt_wrap", 64'(fc[1]), 64'(0));
        continuous = 1'b0;
        send_frame(2, -1, 0, 0); settle_check("t9c");
        check("t9_busy_end", 64'(busy[0]), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
